pipe_fetch_ctrl: RTL and testbench

- IF-stage fetch controller for the pipelined OTTER.
- Owns the PC and issues one instruction-memory request at a time over a variable-latency req/valid interface.
- Delivers fetched instructions to the IF/ID register through a valid/ready slot.
- Consumes the EX-stage branch decision (branchSrc) and jump redirects: retargets the PC, drains any in-flight fetch, and pulses flushes to the younger stages.

---
 rtl/pipe_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_ctrl.sv
// rtl/pipe_fetch_ctrl.sv - IF-stage fetch controller: PC, single-outstanding imem fetch, redirect/flush
module pipe_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        branchSrc,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_ir,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] target;
    logic        capture;
    logic        release_slot;

    // Redirect select: a taken branch outranks a simultaneous jump.
    always_comb begin
        redirect = branchSrc | jump;
        target   = branchSrc ? branch_target : jump_target;
    end

    // Next-state and request decode; a redirect overrides capture/release.
    always_comb begin
        state_nx     = state;
        capture      = 1'b0;
        release_slot = 1'b0;
        case (state)
            BOOT: begin
                state_nx = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // A response in the same cycle closes the old request; otherwise it must be drained.
                    state_nx = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nx = FETCH;
                end else if (if_ready) begin
                    release_slot = 1'b1;
                    state_nx     = FETCH;
                end
            end
            DRAIN: begin
                // The stale response ends the drain whether or not a new redirect lands with it.
                if (imem_valid) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    // Request is only raised in FETCH; pc is frozen there until response or redirect.
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // PC, IF/ID slot and one-cycle flush/misalign pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc           <= RESET_VEC;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_ir        <= 32'h0;
            flush_id     <= 1'b0;
            flush_ex     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            pc           <= {target[31:2], 2'b00};
            if_valid     <= 1'b0;
            flush_id     <= 1'b1;
            flush_ex     <= 1'b1;
            misalign_err <= |target[1:0];
        end else begin
            flush_id     <= 1'b0;
            flush_ex     <= 1'b0;
            misalign_err <= 1'b0;
            if (capture) begin
                if_ir    <= imem_rdata;
                if_pc    <= pc;
                if_valid <= 1'b1;
                pc       <= pc + 32'd4;
            end else if (release_slot) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// tb/tb_pipe_fetch_ctrl.sv - self-checking bench for pipe_fetch_ctrl
module tb_pipe_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        branchSrc = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        flush_id;
    logic        flush_ex;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;

    pipe_fetch_ctrl #(.RESET_VEC(RV)) dut (
        .CLK(CLK), .RST(RST),
        .branchSrc(branchSrc), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_ir(if_ir),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .misalign_err(misalign_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: one outstanding request, answers 'lat' cycles after it is seen.
    int          lat = 1;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = 32'h0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending    = 1'b0;
            imem_valid = 1'b0;
            imem_rdata = 32'h0;
            cnt        = 0;
        end else begin
            #1;
            if (imem_valid) begin
                imem_valid = 1'b0;
                pending    = 1'b0;
            end
            if (!pending && imem_req) begin
                pending = 1'b1;
                maddr   = imem_addr;
                cnt     = 1;
            end else if (pending) begin
                cnt++;
                if (imem_req) chk("addr_stable", imem_addr, maddr);
            end
            if (pending && cnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(maddr);
            end
        end
    end

    // Reference model: next fetch pc, whether a stale response is owed, and the IF/ID slot.
    logic        m_boot = 1'b1;
    logic        m_stale = 1'b0;
    logic        m_full = 1'b0;
    logic [31:0] m_pc = RV;
    logic [31:0] m_slot_pc = 32'h0;
    logic [31:0] m_slot_ir = 32'h0;
    logic        m_flush = 1'b0;
    logic        m_mis = 1'b0;
    logic        m_req;
    logic        redir;
    logic [31:0] tgt;
    logic        seen_10c = 1'b0;

    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
            chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_if_ir", if_ir, 32'h0);
            chk("rst_flush_id", {31'b0, flush_id}, 32'd0);
            chk("rst_flush_ex", {31'b0, flush_ex}, 32'd0);
            chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
            m_boot  = 1'b1;
            m_stale = 1'b0;
            m_full  = 1'b0;
            m_pc    = RV;
            m_flush = 1'b0;
            m_mis   = 1'b0;
        end else begin
            m_req = !m_boot && !m_stale && !m_full;
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
            if (m_req) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_full});
            if (m_full) begin
                chk("if_pc", if_pc, m_slot_pc);
                chk("if_ir", if_ir, m_slot_ir);
            end
            chk("flush_id", {31'b0, flush_id}, {31'b0, m_flush});
            chk("flush_ex", {31'b0, flush_ex}, {31'b0, m_flush});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
            if (if_valid && if_pc == 32'h10C) seen_10c = 1'b1;

            redir   = branchSrc | jump;
            tgt     = branchSrc ? branch_target : jump_target;
            m_flush = redir;
            m_mis   = redir && (tgt[1:0] != 2'b00);
            if (redir) begin
                if (m_req && !imem_valid) m_stale = 1'b1;
                else if (m_stale && imem_valid) m_stale = 1'b0;
                m_full = 1'b0;
                m_boot = 1'b0;
                m_pc   = {tgt[31:2], 2'b00};
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_stale) begin
                if (imem_valid) m_stale = 1'b0;
            end else if (m_full) begin
                if (if_ready) m_full = 1'b0;
            end else if (imem_valid) begin
                m_full    = 1'b1;
                m_slot_pc = m_pc;
                m_slot_ir = mem_word(m_pc);
                m_pc      = m_pc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_req(input logic [31:0] a, input string name);
        int n = 0;
        while (!(imem_req === 1'b1 && imem_addr === a) && n < 60) begin
            step();
            n++;
        end
        chk(name, imem_req ? imem_addr : 32'hFFFF_FFFF, a);
    endtask

    initial begin
        int n;
        repeat (3) step();
        RST = 1'b0;
        step();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);

        // 1-cycle memory streams 0x100, 0x104, then stall on 0x108.
        wait_req(32'h108, "reach_108");
        if_ready = 1'b0;
        repeat (6) begin
            step();
            chk("hold_if_pc", if_pc, 32'h108);
            chk("hold_if_ir", if_ir, mem_word(32'h108));
            chk("hold_req", {31'b0, imem_req}, 32'd0);
        end
        lat = 3;
        if_ready = 1'b1;
        step();
        chk("refetch_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h10C);

        // Branch while the 3-cycle fetch of 0x10C is in flight.
        branchSrc = 1'b1;
        branch_target = 32'h200;
        step();
        branchSrc = 1'b0;
        chk("br_flush_id", {31'b0, flush_id}, 32'd1);
        chk("br_drain_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("br_flush_gone", {31'b0, flush_ex}, 32'd0);
        wait_req(32'h200, "br_target");
        wait_req(32'h204, "after_200");

        // Jump coincident with a response.
        lat = 1;
        n = 0;
        while (imem_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("valid_seen", {31'b0, imem_valid}, 32'd1);
        jump = 1'b1;
        jump_target = 32'h300;
        step();
        jump = 1'b0;
        chk("jmp_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h300);
        chk("jmp_flush_ex", {31'b0, flush_ex}, 32'd1);

        // Branch and jump together: branch target wins.
        branchSrc = 1'b1;
        branch_target = 32'h400;
        jump = 1'b1;
        jump_target = 32'h500;
        step();
        branchSrc = 1'b0;
        jump = 1'b0;
        chk("both_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h400);
        wait_req(32'h404, "after_400");

        // Misaligned redirect.
        jump = 1'b1;
        jump_target = 32'h203;
        step();
        jump = 1'b0;
        chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
        chk("mis_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, 32'h200);
        step();
        chk("mis_gone", {31'b0, misalign_err}, 32'd0);

        // Reset in the middle of a drain.
        lat = 4;
        wait_req(32'h204, "mis_next");
        branchSrc = 1'b1;
        branch_target = 32'h600;
        step();
        branchSrc = 1'b0;
        chk("pre_rst_drain", {31'b0, imem_req}, 32'd0);
        RST = 1'b1;
        #1;
        chk("async_flush_id", {31'b0, flush_id}, 32'd0);
        chk("async_flush_ex", {31'b0, flush_ex}, 32'd0);
        chk("async_req", {31'b0, imem_req}, 32'd0);
        chk("async_if_valid", {31'b0, if_valid}, 32'd0);
        repeat (2) step();
        RST = 1'b0;
        lat = 1;
        step();
        chk("restart_addr", imem_req ? imem_addr : 32'hFFFF_FFFF, RV);
        wait_req(32'h104, "restart_next");
        step();
        chk("no_10c_delivered", {31'b0, seen_10c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
